// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues sequential fetches, buffers in-order responses, flushes on redirect.
// Optional FETCHQ_BYPASS_EN forwards a response straight to IF/ID when the queue is empty.
module fetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   redirect_valid,
   input  logic [31:0]            redirect_pc,
   output logic                   imem_req,
   output logic [31:0]            imem_addr,
   input  logic                   imem_gnt,
   input  logic                   imem_rvalid,
   input  logic [31:0]            imem_rdata,
   output logic                   id_valid,
   output logic [31:0]            id_instr,
   output logic [31:0]            id_pc,
   input  logic                   id_ready,
   output logic [$clog2(DEPTH):0] q_count
);

   localparam int unsigned PW  = $clog2(DEPTH);
   localparam int unsigned CW  = PW + 1;
   localparam logic [CW:0] DepthW = (CW + 1)'(DEPTH);
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic [31:0]   fetchPc_q, fetchPc_d;
   logic [31:0]   respPc_q, respPc_d;
   logic [CW-1:0] inflight_q, inflight_d;
   logic [CW-1:0] discard_q, discard_d;
   logic [CW-1:0] count_q, count_d;
   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [31:0]   instrMem_q [DEPTH];
   logic [31:0]   pcMem_q    [DEPTH];

   logic          isEmpty;
   logic          respNew;
   logic          bypassHit;
   logic          pushEn;
   logic          popEn;
   logic          grant;
   logic [CW:0]   occupancy;
   logic [CW:0]   outstanding;

   assign isEmpty     = (count_q == '0);
   assign occupancy   = {1'b0, count_q} + {1'b0, inflight_q};
   assign outstanding = {1'b0, inflight_q} + {1'b0, discard_q};

   // rst gating keeps the request low while the registers are held in reset
   assign imem_req  = rst && !redirect_valid && (occupancy < DepthW) && (outstanding < DepthW);
   assign imem_addr = fetchPc_q;
   assign grant     = imem_req && imem_gnt;
   assign respNew   = rst && imem_rvalid && (discard_q == '0) && !redirect_valid;
   assign popEn     = !redirect_valid && !isEmpty && id_ready;

`ifdef FETCHQ_BYPASS_EN
   assign bypassHit = respNew && isEmpty;
   assign pushEn    = respNew && !(bypassHit && id_ready);

   always_comb begin
      id_valid = !isEmpty || bypassHit;
      id_instr = NOP;
      id_pc    = respPc_q;
      if (bypassHit) begin
         id_instr = imem_rdata;
         id_pc    = respPc_q;
      end else if (!isEmpty) begin
         id_instr = instrMem_q[head_q];
         id_pc    = pcMem_q[head_q];
      end
   end
`else
   assign bypassHit = 1'b0;
   assign pushEn    = respNew;

   always_comb begin
      id_valid = !isEmpty;
      id_instr = NOP;
      id_pc    = respPc_q;
      if (!isEmpty) begin
         id_instr = instrMem_q[head_q];
         id_pc    = pcMem_q[head_q];
      end
   end
`endif

   assign q_count = count_q;

   always_comb begin
      fetchPc_d  = fetchPc_q;
      respPc_d   = respPc_q;
      inflight_d = inflight_q;
      discard_d  = discard_q;
      count_d    = count_q;
      head_d     = head_q;
      tail_d     = tail_q;
      if (redirect_valid) begin
         // Everything still outstanding becomes wrong-path; a response this cycle retires one of them
         fetchPc_d  = redirect_pc;
         respPc_d   = redirect_pc;
         inflight_d = '0;
         discard_d  = discard_q + inflight_q - CW'(imem_rvalid);
         count_d    = '0;
         head_d     = '0;
         tail_d     = '0;
      end else begin
         if (grant) begin
            fetchPc_d = fetchPc_q + 32'd4;
         end
         inflight_d = inflight_q + CW'(grant) - CW'(respNew);
         if (imem_rvalid && (discard_q != '0)) begin
            discard_d = discard_q - 1'b1;
         end
         if (respNew) begin
            respPc_d = respPc_q + 32'd4;
         end
         if (pushEn) begin
            tail_d = tail_q + 1'b1;
         end
         if (popEn) begin
            head_d = head_q + 1'b1;
         end
         count_d = count_q + CW'(pushEn) - CW'(popEn);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetchPc_q  <= RESET_PC;
         respPc_q   <= RESET_PC;
         inflight_q <= '0;
         discard_q  <= '0;
         count_q    <= '0;
         head_q     <= '0;
         tail_q     <= '0;
      end else begin
         fetchPc_q  <= fetchPc_d;
         respPc_q   <= respPc_d;
         inflight_q <= inflight_d;
         discard_q  <= discard_d;
         count_q    <= count_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
      end
   end

   // Storage needs no reset: an empty queue never exposes its contents
   always_ff @(posedge clk) begin
      if (pushEn) begin
         instrMem_q[tail_q] <= imem_rdata;
         pcMem_q[tail_q]    <= respPc_q;
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue: an in-order memory responder drives the DUT while a
// queue-based model of the fetch rules predicts every output each cycle.
module tb_fetch_queue;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP      = 32'h0000_0013;
`ifdef FETCHQ_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        id_valid;
   logic [31:0] id_instr;
   logic [31:0] id_pc;
   logic        id_ready;
   logic [$clog2(DEPTH):0] q_count;

   int checks = 0;
   int errors = 0;
   int cycle  = 0;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } entry_t;

   typedef struct {
      logic [31:0] addr;
      int          readyAt;
   } pend_t;

   // Reference state: plain counters plus a queue of delivered-but-unconsumed instructions
   logic [31:0] mFetchPc;
   logic [31:0] mRespPc;
   int          mInflight;
   int          mDiscard;
   entry_t      mQueue[$];
   pend_t       memPend[$];

   always #5 clk = ~clk;

   fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk           (clk),
      .rst           (rst),
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_gnt      (imem_gnt),
      .imem_rvalid   (imem_rvalid),
      .imem_rdata    (imem_rdata),
      .id_valid      (id_valid),
      .id_instr      (id_instr),
      .id_pc         (id_pc),
      .id_ready      (id_ready),
      .q_count       (q_count)
   );

   function automatic logic [31:0] memWord(input logic [31:0] addr);
      return (addr * 32'h9E37_79B1) ^ 32'h1357_2468;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s cycle %0d got %h expected %h", tag, cycle, got, exp);
      end
   endtask

   // One clock cycle: drive inputs, compare outputs against the model, then advance the model
   task automatic applyStimulus(input bit rstV, input bit redirV, input logic [31:0] redirPc,
                                input int gntPct, input int readyPct, input int rvalidPct,
                                input int maxLat);
      bit          expReq;
      bit          expValid;
      logic [31:0] expInstr;
      logic [31:0] expPc;
      bit          nonStale;
      bit          bypassTaken;
      int          lat;

      @(posedge clk);
      #1;
      cycle++;
      rst            = rstV;
      redirect_valid = redirV;
      redirect_pc    = redirPc;
      imem_gnt       = ($urandom_range(0, 99) < gntPct);
      id_ready       = ($urandom_range(0, 99) < readyPct);
      imem_rvalid    = 1'b0;
      imem_rdata     = $urandom();
      if (!rstV) begin
         memPend.delete();
         imem_rvalid = $urandom_range(0, 1) == 1;
         mFetchPc  = RESET_PC;
         mRespPc   = RESET_PC;
         mInflight = 0;
         mDiscard  = 0;
         mQueue.delete();
      end else if (memPend.size() > 0 && memPend[0].readyAt <= cycle &&
                   $urandom_range(0, 99) < rvalidPct) begin
         imem_rvalid = 1'b1;
         imem_rdata  = memWord(memPend[0].addr);
         void'(memPend.pop_front());
      end

      nonStale = rstV && imem_rvalid && (mDiscard == 0);
      expReq   = rstV && !redirV && (mQueue.size() + mInflight < DEPTH) &&
                 (mInflight + mDiscard < DEPTH);
      expValid = mQueue.size() > 0;
      expInstr = NOP;
      expPc    = mRespPc;
      if (mQueue.size() > 0) begin
         expInstr = mQueue[0].instr;
         expPc    = mQueue[0].pc;
      end else if (BYPASS && nonStale && !redirV) begin
         expValid = 1'b1;
         expInstr = imem_rdata;
      end

      #4;
      checkOutput("imem_req",  32'(imem_req),  32'(expReq));
      checkOutput("imem_addr", imem_addr,      mFetchPc);
      checkOutput("id_valid",  32'(id_valid),  32'(expValid));
      checkOutput("id_instr",  id_instr,       expInstr);
      checkOutput("id_pc",     id_pc,          expPc);
      checkOutput("q_count",   32'(q_count),   32'(mQueue.size()));
      if (id_valid && id_instr !== NOP) begin
         checkOutput("instr_matches_pc", id_instr, memWord(id_pc));
      end

      if (!rstV) return;
      if (redirV) begin
         mDiscard  = mDiscard + mInflight - (imem_rvalid ? 1 : 0);
         mInflight = 0;
         mQueue.delete();
         mFetchPc  = redirPc;
         mRespPc   = redirPc;
      end else begin
         if (expReq && imem_gnt) begin
            lat = $urandom_range(1, maxLat);
            memPend.push_back('{addr: mFetchPc, readyAt: cycle + lat});
            mFetchPc = mFetchPc + 32'd4;
            mInflight++;
         end
         bypassTaken = BYPASS && mQueue.size() == 0 && nonStale && id_ready;
         if (mQueue.size() > 0 && id_ready) void'(mQueue.pop_front());
         if (imem_rvalid) begin
            if (mDiscard == 0) begin
               mInflight--;
               if (!bypassTaken) mQueue.push_back('{instr: imem_rdata, pc: mRespPc});
               mRespPc = mRespPc + 32'd4;
            end else begin
               mDiscard--;
            end
         end
      end
   endtask

   initial begin
      rst            = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      imem_gnt       = 1'b0;
      imem_rvalid    = 1'b0;
      imem_rdata     = '0;
      id_ready       = 1'b0;
      #2 rst = 1'b0;

      // Reset with junk responses on the bus
      repeat (3) applyStimulus(1'b0, 1'b0, '0, 100, 100, 50, 1);

      // Full-rate streaming after reset release
      repeat (12) applyStimulus(1'b1, 1'b0, '0, 100, 100, 100, 1);

      // Consumer stalls long enough to saturate the queue, then drains
      repeat (10) applyStimulus(1'b1, 1'b0, '0, 100, 0, 100, 1);
      repeat (8) applyStimulus(1'b1, 1'b0, '0, 100, 100, 100, 1);

      // Quiesce, build two in-flight requests, redirect over them
      repeat (8) applyStimulus(1'b1, 1'b0, '0, 0, 100, 100, 1);
      repeat (2) applyStimulus(1'b1, 1'b0, '0, 100, 100, 0, 1);
      applyStimulus(1'b1, 1'b1, 32'h0000_0100, 100, 100, 0, 1);
      repeat (10) applyStimulus(1'b1, 1'b0, '0, 100, 100, 100, 1);

      // Redirect coinciding with a response and a ready consumer
      applyStimulus(1'b1, 1'b1, 32'h0000_0200, 100, 100, 100, 1);
      repeat (6) applyStimulus(1'b1, 1'b0, '0, 100, 100, 100, 1);

      // Fetch address wraps past the top of the address space
      applyStimulus(1'b1, 1'b1, 32'hFFFF_FFF8, 100, 100, 100, 1);
      repeat (8) applyStimulus(1'b1, 1'b0, '0, 100, 100, 100, 1);

      // Reset mid-stream with entries queued
      repeat (5) applyStimulus(1'b1, 1'b0, '0, 100, 0, 100, 1);
      repeat (2) applyStimulus(1'b0, 1'b0, '0, 100, 100, 100, 1);
      repeat (8) applyStimulus(1'b1, 1'b0, '0, 100, 100, 100, 1);

      // Long randomized run with redirects and occasional resets
      repeat (3000) begin
         int dice;
         dice = $urandom_range(0, 999);
         if (dice < 5) begin
            applyStimulus(1'b0, 1'b0, '0, 70, 60, 60, 4);
         end else if (dice < 40) begin
            applyStimulus(1'b1, 1'b1, $urandom() & 32'hFFFF_FFFC, 70, 60, 60, 4);
         end else begin
            applyStimulus(1'b1, 1'b0, '0, 70, 60, 60, 4);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, queue entries; a power of two, 2..16.
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 The block SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-004 The block SHALL have port rst  in  1  reset, asynchronous and active-low.
REQ-005 The block SHALL have port redirect_valid  in  1  branch/jump taken; flush and refetch.
REQ-006 The block SHALL have port redirect_pc  in  32  new fetch address.
REQ-007 The block SHALL have port imem_req  out  1  fetch request valid.
REQ-008 The block SHALL have port imem_addr  out  32  fetch address.
REQ-009 The block SHALL have port imem_gnt  in  1  request accepted this cycle.
REQ-010 The block SHALL have port imem_rvalid  in  1  response valid; in order, one per grant, at least 1 cycle after grant.
REQ-011 The block SHALL have port imem_rdata  in  32  response instruction.
REQ-012 The block SHALL have port id_valid  out  1  instruction available to IF/ID.
REQ-013 The block SHALL have port id_instr  out  32  instruction to IF/ID.
REQ-014 The block SHALL have port id_pc  out  32  address of id_instr.
REQ-015 The block SHALL have port id_ready  in  1  IF/ID consumes; driven as not-retain by the pipeline.
REQ-016 The block SHALL have port q_count  out  $clog2(DEPTH)+1  valid entries held.

Function
REQ-017 The block SHALL keep fetch_pc; imem_addr = fetch_pc; imem_req = !redirect_valid && (q_count+inflight < DEPTH) && (inflight+discard < DEPTH).
REQ-018 On imem_req && imem_gnt, the block SHALL increment fetch_pc by 4 (mod 2^32) and inflight by 1.
REQ-019 On a non-stale response (discard==0), the block SHALL decrement inflight and write {imem_rdata, resp_pc} at the tail; resp_pc += 4.
REQ-020 On a stale response (discard>0), the block SHALL drop the data and decrement discard.
REQ-021 Pop SHALL occur when id_valid && id_ready; head advances, pointers wrap modulo DEPTH.
REQ-022 Simultaneous push and pop SHALL leave q_count unchanged; overflow is impossible by REQ-017.
REQ-023 When empty, the block SHALL drive id_valid=0, id_instr=32'h0000_0013 (NOP), id_pc=resp_pc.
REQ-024 On redirect_valid, the block SHALL clear the queue (q_count=0), set fetch_pc=resp_pc=redirect_pc, discard <= discard+inflight-(non-stale rvalid this cycle), inflight <= 0, and ignore a same-cycle pop.
REQ-025 A response in the redirect cycle SHALL be dropped; if already stale, it decrements discard.
REQ-026 The first post-redirect request SHALL issue the cycle after redirect_valid falls, at redirect_pc.
REQ-027 Without bypass, push-to-id_valid latency SHALL be 1 cycle.

Reset
REQ-028 While rst=0, the block SHALL force fetch_pc=resp_pc=RESET_PC, inflight=discard=0, queue empty, imem_req=0, id_valid=0, id_instr=NOP, id_pc=RESET_PC, q_count=0.
REQ-029 Responses arriving during reset SHALL be ignored; the first request SHALL issue in the first cycle after rst rises.

Configuration
REQ-030 With FETCHQ_BYPASS_EN defined, when the queue is empty and a non-stale response arrives without redirect, the block SHALL present it combinationally (id_valid=1, id_instr=imem_rdata, id_pc=resp_pc) and not store it if id_ready=1 (0-cycle latency); if id_ready=0 it SHALL be stored as usual.
REQ-031 Without FETCHQ_BYPASS_EN, the block SHALL always store responses, with 1-cycle latency and no imem_rdata-to-id_instr combinational path.

Verification
REQ-032 Reset release, gnt=1 always, 1-cycle response, id_ready=1 -> imem_addr 0,4,8,...; id_pc 0,4,8 in order; id_valid continuous from the 3rd cycle.
REQ-033 id_ready=0 for 10 cycles, DEPTH=4 -> q_count saturates at 4, imem_req=0, no data lost; on release pops PCs 0,4,8,12 back-to-back.
REQ-034 Redirect to 32'h0000_0100 with 2 requests in flight -> both stale responses dropped, next id_pc=0x100, queue held 0 wrong-path entries.
REQ-035 Redirect in the same cycle as rvalid and id_ready -> response dropped, no pop counted, q_count=0 next cycle.
REQ-036 fetch_pc=32'hFFFF_FFFC granted -> next imem_addr=32'h0000_0000.
REQ-037 rst=0 asserted mid-stream with 3 entries queued -> all outputs at reset values immediately; refetch starts at RESET_PC.
